// File: rtl/conv10_ofm_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : conv10_ofm_writer_if
//  Brief    : Feature-vector capture inputs and output feature-map RAM write
//             port of conv10_ofm_writer.
//  Revision : 1.0  initial release
// ============================================================================
interface conv10_ofm_writer_if #(
    parameter int WOUT   = 8,
    parameter int DSP_NO = 512,
    parameter int WIDTH  = 16,
    parameter int LANES  = 8,
    parameter int BEATS  = DSP_NO / LANES,
    parameter int AW     = $clog2(2 * WOUT * WOUT * BEATS)
);
    logic [0:DSP_NO-1][WIDTH-1:0] ofm_i;
    logic                         sample_i;
    logic                         layer_sel_i;
    logic                         finish_1_i;
    logic                         finish_2_i;
    logic                         wr_en_o;
    logic [AW-1:0]                wr_addr_o;
    logic [LANES*WIDTH-1:0]       wr_data_o;
    logic                         ram_feedback_1_o;
    logic                         ram_feedback_2_o;
    logic                         busy_o;
    logic                         overflow_o;

    modport master (
        output ofm_i, sample_i, layer_sel_i, finish_1_i, finish_2_i,
        input  wr_en_o, wr_addr_o, wr_data_o, ram_feedback_1_o,
               ram_feedback_2_o, busy_o, overflow_o
    );

    modport slave (
        input  ofm_i, sample_i, layer_sel_i, finish_1_i, finish_2_i,
        output wr_en_o, wr_addr_o, wr_data_o, ram_feedback_1_o,
               ram_feedback_2_o, busy_o, overflow_o
    );
endinterface
`default_nettype wire

// File: rtl/conv10_ofm_writer.sv
`default_nettype none
// ============================================================================
//  Module   : conv10_ofm_writer
//  Brief    : Captures a DSP_NO-word MAC output vector and streams it into the
//             output feature-map RAM, LANES words per beat, tracking per-layer
//             pixel counts and raising per-layer RAM feedback levels.
//             Optional macro CONV10_OFM_RELU_EN applies ReLU to written words.
//  Revision : 1.0  initial release
// ============================================================================
module conv10_ofm_writer #(
    parameter int WOUT   = 8,
    parameter int DSP_NO = 512,
    parameter int WIDTH  = 16,
    parameter int LANES  = 8,
    parameter int BEATS  = DSP_NO / LANES,
    parameter int AW     = $clog2(2 * WOUT * WOUT * BEATS)
) (
    input  logic               clk,
    input  logic               rst,
    conv10_ofm_writer_if.slave bus
);

    localparam int c_PIX_MAX = WOUT * WOUT;
    localparam int c_PW      = $clog2(c_PIX_MAX + 1);
    localparam int c_BW      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int c_CW      = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
    localparam int c_L1_BASE = c_PIX_MAX * BEATS;

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_DRAIN = 1'b1;

    logic [0:0]                   r_state;
    logic [0:0]                   w_state_nxt;
    logic [c_BW-1:0]              r_beat;
    logic                         r_layer;
    logic [c_PW-1:0]              r_pix_1;
    logic [c_PW-1:0]              r_pix_2;
    logic [0:DSP_NO-1][WIDTH-1:0] r_cap;
    logic                         r_fb_1;
    logic                         r_fb_2;
    logic                         r_ovf;

    logic                         w_busy;
    logic                         w_wr_en;
    logic                         w_last;
    logic                         w_open;
    logic                         w_room;
    logic                         w_accept;
    logic                         w_drop;
    logic [c_PW-1:0]              w_pix_1_eff;
    logic [c_PW-1:0]              w_pix_2_eff;
    logic [c_PW-1:0]              w_cur_pix;
    logic [AW-1:0]                w_base;
    logic [AW-1:0]                w_addr;
    logic [LANES-1:0][WIDTH-1:0]  w_lane;

    // Counts as they will stand after this edge, so a sample arriving on the
    // final beat sees the pixel that is just being completed.
    assign w_last      = (r_state == c_S_DRAIN) && (r_beat == c_BW'(BEATS - 1));
    assign w_pix_1_eff = r_pix_1 + c_PW'(w_last && !r_layer && (r_pix_1 != c_PW'(c_PIX_MAX)));
    assign w_pix_2_eff = r_pix_2 + c_PW'(w_last &&  r_layer && (r_pix_2 != c_PW'(c_PIX_MAX)));

    assign w_open   = (r_state == c_S_IDLE) || w_last;
    assign w_room   = bus.layer_sel_i ? (w_pix_2_eff != c_PW'(c_PIX_MAX))
                                      : (w_pix_1_eff != c_PW'(c_PIX_MAX));
    assign w_accept = bus.sample_i && w_open && w_room;
    assign w_drop   = bus.sample_i && !w_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = c_S_DRAIN;
                end
            end
            c_S_DRAIN: begin
                if (w_last && !w_accept) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_busy  = 1'b0;
        w_wr_en = 1'b0;
        if (r_state == c_S_DRAIN) begin
            w_busy  = 1'b1;
            w_wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat  <= '0;
            r_layer <= 1'b0;
            r_pix_1 <= '0;
            r_pix_2 <= '0;
            r_fb_1  <= 1'b0;
            r_fb_2  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_beat  <= '0;
                r_layer <= bus.layer_sel_i;
            end else if (r_state == c_S_DRAIN) begin
                r_beat  <= r_beat + c_BW'(1);
            end
            r_pix_1 <= w_pix_1_eff;
            r_pix_2 <= w_pix_2_eff;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            // A layer is stored once its last pixel has left the write port.
            if (bus.finish_1_i && (r_pix_1 == c_PW'(c_PIX_MAX)) && (!w_busy || r_layer)) begin
                r_fb_1 <= 1'b1;
            end
            if (bus.finish_2_i && (r_pix_2 == c_PW'(c_PIX_MAX)) && (!w_busy || !r_layer)) begin
                r_fb_2 <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_cap <= bus.ofm_i;
        end
    end

    assign w_cur_pix = r_layer ? r_pix_2 : r_pix_1;
    assign w_base    = r_layer ? AW'(c_L1_BASE) : '0;
    assign w_addr    = w_base + AW'(w_cur_pix) * AW'(BEATS) + AW'(r_beat);

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [c_CW-1:0]  w_idx;
        logic [WIDTH-1:0] w_word;
        assign w_idx  = c_CW'(r_beat) * c_CW'(LANES) + c_CW'(j);
        assign w_word = r_cap[w_idx];
`ifdef CONV10_OFM_RELU_EN
        assign w_lane[j] = (w_busy && !w_word[WIDTH-1]) ? w_word : '0;
`else
        assign w_lane[j] = w_busy ? w_word : '0;
`endif
    end

    assign bus.wr_en_o          = w_wr_en;
    assign bus.wr_addr_o        = w_wr_en ? w_addr : '0;
    assign bus.wr_data_o        = w_lane;
    assign bus.busy_o           = w_busy;
    assign bus.overflow_o       = r_ovf;
    assign bus.ram_feedback_1_o = r_fb_1;
    assign bus.ram_feedback_2_o = r_fb_2;

endmodule
`default_nettype wire

// File: tb/tb_conv10_ofm_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv10_ofm_writer
//  Brief    : Scoreboard bench for conv10_ofm_writer: directed samples push
//             expected RAM beats, a negedge monitor pops and compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv10_ofm_writer;

    localparam int WOUT   = 8;
    localparam int DSP_NO = 512;
    localparam int WIDTH  = 16;
    localparam int LANES  = 8;
    localparam int BEATS  = 64;
    localparam int AW     = 13;
    localparam int PIXN   = WOUT * WOUT;

    typedef struct packed {
        logic [AW-1:0]          addr;
        logic [LANES*WIDTH-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv10_ofm_writer_if #(.WOUT(WOUT), .DSP_NO(DSP_NO), .WIDTH(WIDTH),
                           .LANES(LANES), .BEATS(BEATS), .AW(AW)) bus ();

    conv10_ofm_writer #(.WOUT(WOUT), .DSP_NO(DSP_NO), .WIDTH(WIDTH),
                        .LANES(LANES), .BEATS(BEATS), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    beat_t exp_q[$];
    int    n_tests     = 0;
    int    n_fail      = 0;
    int    wr_cycles   = 0;
    int    busy_cycles = 0;
    logic [0:DSP_NO-1][WIDTH-1:0] vec;

    function automatic logic [WIDTH-1:0] relu(input logic [WIDTH-1:0] w);
`ifdef CONV10_OFM_RELU_EN
        return w[WIDTH-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Builds a vector (k*mul+add, 15 bits), optionally with sign-bit words,
    // drives a one-cycle sample and queues the expected beats when accepted.
    task automatic send(input bit layer, input int mul, input int add,
                        input bit neg, input bit push, input int pix);
        beat_t e;
        for (int k = 0; k < DSP_NO; k++) vec[k] = WIDTH'((k * mul + add) & 32'h7FFF);
        if (neg) begin
            vec[0] = 16'h8001;
            vec[9] = 16'hFFFF;
        end
        bus.ofm_i       = vec;
        bus.layer_sel_i = layer;
        bus.sample_i    = 1'b1;
        if (push) begin
            for (int b = 0; b < BEATS; b++) begin
                e.addr = AW'((layer ? PIXN * BEATS : 0) + pix * BEATS + b);
                e.data = '0;
                for (int j = 0; j < LANES; j++)
                    e.data[j*WIDTH +: WIDTH] = relu(vec[b*LANES + j]);
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        bus.sample_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.busy_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        #1;
        check(name, 64'(bus.busy_o), 64'd0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (bus.busy_o) busy_cycles++;
        if (bus.wr_en_o) begin
            wr_cycles++;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %h, expected no write",
                         bus.wr_addr_o, bus.wr_data_o);
            end else begin
                e = exp_q.pop_front();
                if (bus.wr_addr_o !== e.addr || bus.wr_data_o !== e.data) begin
                    n_fail++;
                    $display("FAIL write_beat: addr %0d data %h, expected addr %0d data %h",
                             bus.wr_addr_o, bus.wr_data_o, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, w0;
        bus.ofm_i       = '0;
        bus.sample_i    = 1'b0;
        bus.layer_sel_i = 1'b0;
        bus.finish_1_i  = 1'b0;
        bus.finish_2_i  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_en",    64'(bus.wr_en_o),          64'd0);
        check("rst_wr_addr",  64'(bus.wr_addr_o),        64'd0);
        check("rst_wr_data",  64'(bus.wr_data_o != '0),  64'd0);
        check("rst_busy",     64'(bus.busy_o),           64'd0);
        check("rst_overflow", 64'(bus.overflow_o),       64'd0);
        check("rst_fb1",      64'(bus.ram_feedback_1_o), 64'd0);
        check("rst_fb2",      64'(bus.ram_feedback_2_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single sample, layer 0, ofm[k] = k: addresses 0..63.
        #1; b0 = busy_cycles; w0 = wr_cycles;
        send(1'b0, 1, 0, 1'b0, 1'b1, 0);
        repeat (64) @(negedge clk);
        #1;
        check("single_busy_cycles", 64'(busy_cycles - b0), 64'd64);
        check("single_wr_cycles",   64'(wr_cycles - w0),   64'd64);
        check("single_end_busy",    64'(bus.busy_o),       64'd0);

        // Back-to-back: pixels 1 and 2 of layer 0 with no gap.
        @(negedge clk); #1; b0 = busy_cycles; w0 = wr_cycles;
        send(1'b0, 3, 100, 1'b0, 1'b1, 1);
        repeat (63) @(negedge clk);
        send(1'b0, 5, 7, 1'b0, 1'b1, 2);
        repeat (64) @(negedge clk);
        #1;
        check("b2b_wr_cycles",   64'(wr_cycles - w0),   64'd128);
        check("b2b_busy_cycles", 64'(busy_cycles - b0), 64'd128);
        check("b2b_overflow",    64'(bus.overflow_o),   64'd0);

        // Sample at beat 10 of pixel 3 is dropped; next capture is pixel 4.
        @(negedge clk);
        send(1'b0, 2, 3, 1'b0, 1'b1, 3);
        repeat (10) @(negedge clk);
        check("drop_ovf_before", 64'(bus.overflow_o), 64'd0);
        send(1'b0, 9, 9, 1'b0, 1'b0, 0);
        #1;
        check("drop_ovf_after", 64'(bus.overflow_o), 64'd1);
        check("drop_still_busy", 64'(bus.busy_o), 64'd1);
        wait_idle("drop_drain_done");
        send(1'b0, 1, 1, 1'b0, 1'b1, 4);
        wait_idle("pix4_drain_done");

        // Reset at beat 30 of pixel 5 abandons the capture.
        send(1'b0, 1, 2, 1'b0, 1'b1, 5);
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_wr_en", 64'(bus.wr_en_o), 64'd0);
        check("midrst_busy",  64'(bus.busy_o),  64'd0);
        exp_q.delete();
        @(negedge clk);
        check("midrst_overflow", 64'(bus.overflow_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // After reset: pixel 0 again, with sign-bit words for the ReLU path.
        send(1'b0, 1, 0, 1'b1, 1'b1, 0);
        wait_idle("relu_drain_done");

        // Fill layer 1 back to back; last write lands at 8191.
        for (int p = 0; p < PIXN; p++) begin
            send(1'b1, 1, p * 11, 1'b0, 1'b1, p);
            repeat (p == PIXN - 1 ? 64 : 63) @(negedge clk);
        end
        #1;
        check("l1_busy_done", 64'(bus.busy_o),           64'd0);
        check("l1_fb2_pre",   64'(bus.ram_feedback_2_o), 64'd0);
        bus.finish_1_i = 1'b1;
        bus.finish_2_i = 1'b1;
        #1;
        check("l1_fb2_same_cycle", 64'(bus.ram_feedback_2_o), 64'd0);
        @(posedge clk); #1;
        check("l1_fb2_set", 64'(bus.ram_feedback_2_o), 64'd1);
        check("l1_fb1_low", 64'(bus.ram_feedback_1_o), 64'd0);

        // Layer 1 saturated: further sample is dropped.
        @(negedge clk);
        check("sat_ovf_before", 64'(bus.overflow_o), 64'd0);
        send(1'b1, 1, 0, 1'b0, 1'b0, 0);
        #1;
        check("sat_ovf_after", 64'(bus.overflow_o),       64'd1);
        check("sat_not_busy",  64'(bus.busy_o),           64'd0);
        check("sat_fb2_hold",  64'(bus.ram_feedback_2_o), 64'd1);
        repeat (4) @(negedge clk);
        #1;
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
